pipe_skid_latch: RTL
====================

Name: pipe_skid_latch

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core; the successor to the per-stage fixed-field latches.
- Carries an opaque WIDTH-bit payload (the packed stage control/data struct) with valid/ready handshake.
- Includes a one-entry skid buffer, so upstream stalls never need a combinational ready path.
- Provides flush (bubble insertion) with priority over hold (freeze); empty slots present a configurable bubble/nop value.

Parameters:
- WIDTH, 96, payload width in bits.
- BUBBLE_VAL, '0, payload driven on out_data when empty and loaded on reset/flush (nop encoding).
- CNT_W, 32, width of the performance counters; used only when PIPE_SKID_LATCH_PERF_EN is defined.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage has a payload.
- in_ready  out  1  latch accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  registered payload.
- flush  in  1  squash all held entries (branch/jump resolved).
- hold  in  1  hazard-unit freeze.
- occupancy  out  2  held entries: 0, 1 or 2.
- stall_cnt  out  CNT_W  present only with PIPE_SKID_LATCH_PERF_EN.
- flush_cnt  out  CNT_W  present only with PIPE_SKID_LATCH_PERF_EN.

Behaviour:
- Storage:
  - main register: valid bit plus data; drives out_data.
  - skid register: valid bit plus data.
  - States: PL_EMPTY (neither valid), PL_FULL (main only), PL_SKID (both valid).
- Reset (nRST low, async):
  - Both valid bits = 0; both data registers = BUBBLE_VAL; state = PL_EMPTY.
  - Outputs: out_valid = 0, out_data = BUBBLE_VAL, occupancy = 0, in_ready = 0 while in reset, counters = 0.
  - Reset mid-transfer discards all entries.
- Combinational outputs:
  - in_ready = !skid_valid && !hold && !flush
  - out_valid = main_valid && !hold
  - in_fire = in_valid && in_ready
  - out_fire = out_valid && out_ready
- Priority: flush > hold > normal transfer.
- flush:
  - Next state is PL_EMPTY; both data registers = BUBBLE_VAL.
  - in_data on the flush cycle is dropped.
  - flush while hold: flush wins.
- hold (without flush): all registers keep their values; no fire on either side.
- PL_EMPTY:
  - in_fire: main <= in_data; go to PL_FULL.
- PL_FULL:
  - in_fire && out_fire: main <= in_data; stay in PL_FULL.
  - in_fire && !out_fire: skid <= in_data; go to PL_SKID.
  - !in_fire && out_fire: main <= BUBBLE_VAL; go to PL_EMPTY.
  - Neither: stay.
- PL_SKID:
  - in_ready = 0.
  - out_fire: main <= skid; skid <= BUBBLE_VAL; go to PL_FULL.
- Timing:
  - Latency in_fire to out_valid is 1 cycle.
  - Sustained throughput is 1 per cycle.
  - No combinational path from out_ready to in_ready.
- Ordering: payloads leave in strict arrival order; no duplication, no loss except by flush.
- occupancy = main_valid + skid_valid.

Optional Feature:
- Macro: PIPE_SKID_LATCH_PERF_EN.
- When defined:
  - stall_cnt increments each cycle with main_valid && !out_fire && !flush.
  - flush_cnt adds occupancy (squashed entries, 0..2) on each flush cycle.
  - Both counters saturate at all-ones and clear on reset.
- When undefined: counter ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_latch_pkg:
  - typedef enum logic [1:0] {PL_EMPTY, PL_FULL, PL_SKID} pl_state_t
  - typedef logic [1:0] pl_occ_t
- Stage payload structs stay in cpu_types_pkg.
- Optional sub-module sat_counter (parameter CNT_W; inputs inc amount and clear), instantiated twice under the macro.

Test Plan (WIDTH=8, BUBBLE_VAL=0):
- Streaming: out_ready=1; push 0x11, 0x22, 0x33 on consecutive cycles → out_data shows 0x11, 0x22, 0x33 one cycle later each; occupancy stays at 1; in_ready stays at 1.
- Skid fill/drain:
  - Push 0xA1 with out_ready=0, then push 0xA2 → occupancy=2, in_ready=0.
  - Raise out_ready → outputs 0xA1 then 0xA2; occupancy goes 2→1→0; out_data returns to 0x00.
- Flush: state PL_SKID holding 0xB1/0xB2; assert flush with in_valid=1 and in_data=0xB3 → next cycle out_valid=0, out_data=0x00, occupancy=0; 0xB3 never appears; flush_cnt=2 (with macro).
- Hold: PL_FULL holding 0xC1; hold=1 for 3 cycles with out_ready=1 and in_valid=1 → out_valid=0, in_ready=0, 0xC1 retained; after release, 0xC1 transfers on the first cycle.
- Async reset mid-stream: drop nRST between clock edges while occupancy=2 → all outputs reset immediately (out_data=0x00, occupancy=0); no payload emitted after release until a new push.
- Counter saturation (macro, CNT_W=4): hold main_valid with out_ready=0 for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_latch_pkg.sv
// Shared types for the skid-buffered inter-stage pipeline latch.
package pipe_latch_pkg;

   typedef enum logic [1:0] {
      PL_EMPTY = 2'd0,
      PL_FULL  = 2'd1,
      PL_SKID  = 2'd2
   } pl_state_t;

   typedef logic [1:0] pl_occ_t;

   // Number of live entries held by the main and skid registers.
   function automatic pl_occ_t occ_of(input logic main_v, input logic skid_v);
      return pl_occ_t'({1'b0, main_v}) + pl_occ_t'({1'b0, skid_v});
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter adding 0..3 per cycle; used for latch performance stats.
module sat_counter
   import pipe_latch_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             clear,
   input  pl_occ_t          inc,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned SUM_W = CNT_W + 1;

   logic [SUM_W-1:0] sum;

   assign sum = {1'b0, count} + SUM_W'(inc);

   // Carry out of the top bit pins the counter at all-ones.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (sum[CNT_W]) begin
         count <= '1;
      end else begin
         count <= sum[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/pipe_skid_latch.sv
// Inter-stage pipeline register with one-entry skid buffer, flush and hold.
// Optional performance counters are built when PIPE_SKID_LATCH_PERF_EN is defined.
module pipe_skid_latch
   import pipe_latch_pkg::*;
#(
   parameter int unsigned     WIDTH      = 96,
   parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
`ifdef PIPE_SKID_LATCH_PERF_EN
   ,
   parameter int unsigned     CNT_W      = 32
`endif
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic             hold,
   output pl_occ_t          occupancy
`ifdef PIPE_SKID_LATCH_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   pl_state_t        state;
   logic             main_valid;
   logic             skid_valid;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             in_fire;
   logic             out_fire;

   // in_ready depends only on registered state and control, never on out_ready.
   assign in_ready  = nRST && !skid_valid && !hold && !flush;
   assign out_valid = main_valid && !hold;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign out_data  = main_data;
   assign occupancy = occ_of(main_valid, skid_valid);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state      <= PL_EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= BUBBLE_VAL;
         skid_data  <= BUBBLE_VAL;
      end else if (flush) begin
         state      <= PL_EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= BUBBLE_VAL;
         skid_data  <= BUBBLE_VAL;
      end else if (!hold) begin
         case (state)
            PL_EMPTY: begin
               if (in_fire) begin
                  main_data  <= in_data;
                  main_valid <= 1'b1;
                  state      <= PL_FULL;
               end
            end
            PL_FULL: begin
               if (in_fire && out_fire) begin
                  main_data <= in_data;
               end else if (in_fire) begin
                  skid_data  <= in_data;
                  skid_valid <= 1'b1;
                  state      <= PL_SKID;
               end else if (out_fire) begin
                  main_data  <= BUBBLE_VAL;
                  main_valid <= 1'b0;
                  state      <= PL_EMPTY;
               end
            end
            PL_SKID: begin
               if (out_fire) begin
                  main_data  <= skid_data;
                  skid_data  <= BUBBLE_VAL;
                  skid_valid <= 1'b0;
                  state      <= PL_FULL;
               end
            end
            default: begin
               state      <= PL_EMPTY;
               main_valid <= 1'b0;
               skid_valid <= 1'b0;
               main_data  <= BUBBLE_VAL;
               skid_data  <= BUBBLE_VAL;
            end
         endcase
      end
   end

`ifdef PIPE_SKID_LATCH_PERF_EN
   pl_occ_t stall_inc;
   pl_occ_t flush_inc;

   // Stall counts a held entry that did not leave; flush counts squashed entries.
   assign stall_inc = pl_occ_t'({1'b0, main_valid && !out_fire && !flush});
   assign flush_inc = flush ? occupancy : pl_occ_t'(0);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .clear (1'b0),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .CLK   (CLK),
      .nRST  (nRST),
      .clear (1'b0),
      .inc   (flush_inc),
      .count (flush_cnt)
   );
`endif

endmodule
